ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Pipeline control carrier for the 5-stage MIPS datapath. Accepts the decoded control bundle and register fields from the ID stage and carries them through the ID/EX, EX/MEM and MEM/WB registers, delivering each signal to the stage that consumes it. Also generates the load-use stall, the branch-taken flush bubbles and the EX operand forwarding selects.

## Interface
Parameters:
- REG_W, 5, register-specifier width
- AOP_W, 2, AluOP width

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch  in  1 each  decoded control from ID
- id_AluOP  in  AOP_W  decoded ALU op class
- id_rs, id_rt, id_rd  in  REG_W each  instruction fields
- branch_taken  in  1  MEM-stage branch resolved taken
- ex_ALUSrc  out  1
- ex_AluOP  out  AOP_W
- ex_rs, ex_rt  out  REG_W  for EX operand muxing
- mem_MemRead, mem_MemWrite, mem_Branch  out  1 each
- wb_MemtoReg, wb_RegWrite  out  1 each
- wb_dest  out  REG_W  write-back register
- stall  out  1  hold PC and IF/ID this cycle
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB

## Operation
- Sanitize on capture: the decoder emits X for don't-care fields (sw/beq RegDst, MemtoReg; unknown opcode). A captured stage with id_valid=0 or a bubble stores all controls 0. Any X on a control input is stored as 0. Dest is forced to 0 whenever RegWrite=0.
- ID/EX: captures bundle, rs, rt, rd. EX computes dest = RegDst ? rd : rt. The computed dest, MemRead, MemWrite, Branch, MemtoReg and RegWrite go to EX/MEM. MemtoReg, RegWrite and dest go on to MEM/WB.
- Load-use stall (combinational): stall = ex_MemRead & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt) & id_valid & !branch_taken.
- When stall=1: ID/EX loads a bubble. EX/MEM and MEM/WB advance normally.
- Flush: when branch_taken=1, ID/EX and EX/MEM load bubbles at the next edge. MEM/WB advances (the branch itself writes nothing). Flush overrides stall.
- Forwarding (combinational from registered state), for ex_rs:
  - fwd_a=10 if mem_RegWrite & mem_dest!=0 & mem_dest==ex_rs.
  - Otherwise fwd_a=01 if wb_RegWrite & wb_dest!=0 & wb_dest==ex_rs.
  - Otherwise fwd_a=00.
  - fwd_b: same rules on ex_rt. EX/MEM has priority over MEM/WB.
- Register $0 never forwards and never causes a stall.

## Timing
- All registers update on rising clk.
- reset_n=0 at an edge clears every stage register to 0. After that edge all outputs read 0, including stall and fwd_a/fwd_b.
- Reset mid-operation discards all in-flight instructions; there is no drain.
- Latency: a control bit presented at ID appears at ex_* 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later.
- stall and fwd are valid in the same cycle as their causes, with no register delay.
- Stall lasts exactly 1 cycle per load-use pair: after the bubble, ex_MemRead=0.
- Simultaneous branch_taken and load-use condition: stall=0, flush wins.

## Structure
- Shared package ctrl_pkg holds:
  - ctrl_t, a packed struct {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, AluOP}
  - the bubble constant CTRL_NOP (all zero)
  - the FWD_RF/FWD_MEM/FWD_WB encodings
  - the MIPS opcode constants (R=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000, j=000010)
- The stage registers and stall/flush muxing stay in ctrl_pipe.
- Forwarding comparison lives in one sub-module, fwd_unit, instanced once and producing both selects.

## Test plan
- **Control latency.** Single R-type add (rs=1, rt=2, rd=3, RegWrite=1, RegDst=1, AluOP=10) after reset → ex_AluOP=10 at +1, wb_RegWrite=1 and wb_dest=3 at +3, stall=0 throughout.
- **Load-use stall.** lw rt=4, then add rs=4 → stall=1 for one cycle, then ex_* all 0 (bubble). The next cycle shows the add in EX with fwd_a=01.
- **Forwarding priority.** add rd=5, addi rt=5, add rs=5 rt=5 back-to-back → third instruction sees fwd_a=fwd_b=10 (EX/MEM beats MEM/WB). With a nop between them → 01.
- **Branch flush.** beq taken with 2 younger instructions in flight (sw, add rd=7) → branch_taken=1 yields mem_MemWrite=0 and no wb_RegWrite for rd=7. The instruction already in MEM/WB still writes.
- **X sanitizing and $0.** sw with RegDst/MemtoReg driven X → wb_dest=0 and wb_RegWrite=0, never X. Writes to $0 followed by a read of $0 → fwd=00 and stall=0.
- **Reset mid-pipe.** reset_n=0 for one edge with 3 instructions in flight → all outputs 0 next cycle, and no subsequent wb_RegWrite.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-bundle types, forwarding encodings and MIPS opcodes for
// the pipeline control carrier.
package ctrl_pkg;

  localparam int CTRL_AOP_W = 2;

  typedef struct packed {
    logic                  RegDst;
    logic                  ALUSrc;
    logic                  MemtoReg;
    logic                  RegWrite;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  Branch;
    logic [CTRL_AOP_W-1:0] AluOP;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // Decoder don't-cares arrive as X; only a definite 1 survives capture.
  function automatic ctrl_t sanitize(input ctrl_t c);
    logic [$bits(ctrl_t)-1:0] raw;
    logic [$bits(ctrl_t)-1:0] clean;
    raw = c;
    for (int i = 0; i < $bits(ctrl_t); i++) clean[i] = (raw[i] === 1'b1);
    return ctrl_t'(clean);
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// ID-side inputs and per-stage control outputs of the pipeline control carrier.
interface ctrl_pipe_if
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int AOP_W = 2
);

  logic             id_valid;
  logic             id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
  logic             id_MemRead, id_MemWrite, id_Branch;
  logic [AOP_W-1:0] id_AluOP;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic             branch_taken;

  logic             ex_ALUSrc;
  logic [AOP_W-1:0] ex_AluOP;
  logic [REG_W-1:0] ex_rs, ex_rt;
  logic             mem_MemRead, mem_MemWrite, mem_Branch;
  logic             wb_MemtoReg, wb_RegWrite;
  logic [REG_W-1:0] wb_dest;
  logic             stall;
  logic [1:0]       fwd_a, fwd_b;

  modport master (
    output id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
           id_MemRead, id_MemWrite, id_Branch, id_AluOP, id_rs, id_rt, id_rd,
           branch_taken,
    input  ex_ALUSrc, ex_AluOP, ex_rs, ex_rt, mem_MemRead, mem_MemWrite,
           mem_Branch, wb_MemtoReg, wb_RegWrite, wb_dest, stall, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
           id_MemRead, id_MemWrite, id_Branch, id_AluOP, id_rs, id_rt, id_rd,
           branch_taken,
    output ex_ALUSrc, ex_AluOP, ex_rs, ex_rt, mem_MemRead, mem_MemWrite,
           mem_Branch, wb_MemtoReg, wb_RegWrite, wb_dest, stall, fwd_a, fwd_b
  );

endinterface

// File: rtl/ctrl_pipe_fwd_unit.sv
// EX operand forwarding selects; the younger EX/MEM result wins over MEM/WB.
module fwd_unit
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_dest,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  function automatic logic [1:0] pick(
    input logic [REG_W-1:0] src,
    input logic             m_we,
    input logic [REG_W-1:0] m_dst,
    input logic             w_we,
    input logic [REG_W-1:0] w_dst
  );
    if (m_we && (m_dst != '0) && (m_dst == src)) return FWD_MEM;
    if (w_we && (w_dst != '0) && (w_dst == src)) return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = pick(ex_rs, mem_reg_write, mem_dest, wb_reg_write, wb_dest);
    fwd_b = pick(ex_rt, mem_reg_write, mem_dest, wb_reg_write, wb_dest);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoded MIPS control through ID/EX, EX/MEM and MEM/WB and produces
// the load-use stall, branch flush bubbles and EX forwarding selects.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int AOP_W = 2
) (
  input logic        clk,
  input logic        reset_n,
  ctrl_pipe_if.slave bus
);

  ctrl_t            id_ctrl;
  ctrl_t            ex_ctrl_d, ex_ctrl_q;
  logic [REG_W-1:0] ex_rs_d, ex_rs_q, ex_rt_d, ex_rt_q, ex_rd_d, ex_rd_q;
  logic [REG_W-1:0] ex_dest;
  logic             mem_mem_read_d, mem_mem_read_q;
  logic             mem_mem_write_d, mem_mem_write_q;
  logic             mem_branch_d, mem_branch_q;
  logic             mem_memto_reg_d, mem_memto_reg_q;
  logic             mem_reg_write_d, mem_reg_write_q;
  logic [REG_W-1:0] mem_dest_d, mem_dest_q;
  logic             wb_memto_reg_d, wb_memto_reg_q;
  logic             wb_reg_write_d, wb_reg_write_q;
  logic [REG_W-1:0] wb_dest_d, wb_dest_q;
  logic             stall, flush;
  logic [1:0]       fwd_a, fwd_b;

  function automatic logic [REG_W-1:0] clean_reg(input logic [REG_W-1:0] r);
    logic [REG_W-1:0] c;
    for (int i = 0; i < REG_W; i++) c[i] = (r[i] === 1'b1);
    return c;
  endfunction

  always_comb begin
    id_ctrl          = CTRL_NOP;
    id_ctrl.RegDst   = bus.id_RegDst;
    id_ctrl.ALUSrc   = bus.id_ALUSrc;
    id_ctrl.MemtoReg = bus.id_MemtoReg;
    id_ctrl.RegWrite = bus.id_RegWrite;
    id_ctrl.MemRead  = bus.id_MemRead;
    id_ctrl.MemWrite = bus.id_MemWrite;
    id_ctrl.Branch   = bus.id_Branch;
    id_ctrl.AluOP    = CTRL_AOP_W'(bus.id_AluOP);
  end

  // A taken branch squashes the dependent instruction anyway, so it cancels the stall.
  assign flush = bus.branch_taken;
  assign stall = ex_ctrl_q.MemRead && (ex_rt_q != '0) &&
                 ((ex_rt_q == bus.id_rs) || (ex_rt_q == bus.id_rt)) &&
                 bus.id_valid && !flush;

  always_comb begin
    ex_ctrl_d = CTRL_NOP;
    ex_rs_d   = '0;
    ex_rt_d   = '0;
    ex_rd_d   = '0;
    if (bus.id_valid && !stall && !flush) begin
      ex_ctrl_d = sanitize(id_ctrl);
      ex_rs_d   = clean_reg(bus.id_rs);
      ex_rt_d   = clean_reg(bus.id_rt);
      ex_rd_d   = clean_reg(bus.id_rd);
    end
  end

  assign ex_dest = !ex_ctrl_q.RegWrite ? '0 : (ex_ctrl_q.RegDst ? ex_rd_q : ex_rt_q);

  always_comb begin
    mem_mem_read_d  = 1'b0;
    mem_mem_write_d = 1'b0;
    mem_branch_d    = 1'b0;
    mem_memto_reg_d = 1'b0;
    mem_reg_write_d = 1'b0;
    mem_dest_d      = '0;
    if (!flush) begin
      mem_mem_read_d  = ex_ctrl_q.MemRead;
      mem_mem_write_d = ex_ctrl_q.MemWrite;
      mem_branch_d    = ex_ctrl_q.Branch;
      mem_memto_reg_d = ex_ctrl_q.MemtoReg;
      mem_reg_write_d = ex_ctrl_q.RegWrite;
      mem_dest_d      = ex_dest;
    end
  end

  always_comb begin
    wb_memto_reg_d = mem_memto_reg_q;
    wb_reg_write_d = mem_reg_write_q;
    wb_dest_d      = mem_dest_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_ctrl_q       <= CTRL_NOP;
      ex_rs_q         <= '0;
      ex_rt_q         <= '0;
      ex_rd_q         <= '0;
      mem_mem_read_q  <= 1'b0;
      mem_mem_write_q <= 1'b0;
      mem_branch_q    <= 1'b0;
      mem_memto_reg_q <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_dest_q      <= '0;
      wb_memto_reg_q  <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_dest_q       <= '0;
    end else begin
      ex_ctrl_q       <= ex_ctrl_d;
      ex_rs_q         <= ex_rs_d;
      ex_rt_q         <= ex_rt_d;
      ex_rd_q         <= ex_rd_d;
      mem_mem_read_q  <= mem_mem_read_d;
      mem_mem_write_q <= mem_mem_write_d;
      mem_branch_q    <= mem_branch_d;
      mem_memto_reg_q <= mem_memto_reg_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_dest_q      <= mem_dest_d;
      wb_memto_reg_q  <= wb_memto_reg_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_dest_q       <= wb_dest_d;
    end
  end

  fwd_unit #(.REG_W(REG_W)) u_fwd (
    .ex_rs         (ex_rs_q),
    .ex_rt         (ex_rt_q),
    .mem_reg_write (mem_reg_write_q),
    .mem_dest      (mem_dest_q),
    .wb_reg_write  (wb_reg_write_q),
    .wb_dest       (wb_dest_q),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  assign bus.ex_ALUSrc    = ex_ctrl_q.ALUSrc;
  assign bus.ex_AluOP     = AOP_W'(ex_ctrl_q.AluOP);
  assign bus.ex_rs        = ex_rs_q;
  assign bus.ex_rt        = ex_rt_q;
  assign bus.mem_MemRead  = mem_mem_read_q;
  assign bus.mem_MemWrite = mem_mem_write_q;
  assign bus.mem_Branch   = mem_branch_q;
  assign bus.wb_MemtoReg  = wb_memto_reg_q;
  assign bus.wb_RegWrite  = wb_reg_write_q;
  assign bus.wb_dest      = wb_dest_q;
  assign bus.stall        = stall;
  assign bus.fwd_a        = fwd_a;
  assign bus.fwd_b        = fwd_b;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: hand-computed vector table for the directed corner cases,
// then random traffic, all checked against an instruction-level pipeline model.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  typedef struct packed {
    logic       valid;
    logic       reg_dst;
    logic       alu_src;
    logic       memto_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  typedef struct {
    logic       rst_n;
    instr_t     id;
    logic       bt;
    logic       x_dst;
    logic       chk;
    logic       e_stall;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
    logic [1:0] e_aop;
    logic       e_mw;
    logic       e_rw;
    logic [4:0] e_dest;
  } vec_t;

  localparam instr_t NOP = '0;

  logic   clk = 1'b0;
  logic   reset_n;
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  logic   last_stall = 1'b0;
  instr_t pipe_m [3];
  vec_t   tbl [$];

  ctrl_pipe_if #(.REG_W(5), .AOP_W(2)) bus ();

  ctrl_pipe #(.REG_W(5), .AOP_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(input logic rdst, input logic asrc, input logic m2r,
                                input logic rw, input logic mr, input logic mw,
                                input logic br, input logic [1:0] aop,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd);
    instr_t i;
    i = '{valid: 1'b1, reg_dst: rdst, alu_src: asrc, memto_reg: m2r, reg_write: rw,
          mem_read: mr, mem_write: mw, branch: br, alu_op: aop, rs: rs, rt: rt, rd: rd};
    return i;
  endfunction

  function automatic instr_t i_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return mk(1, 0, 0, 1, 0, 0, 0, 2'b10, rs, rt, rd);
  endfunction
  function automatic instr_t i_lw(input logic [4:0] rs, input logic [4:0] rt);
    return mk(0, 1, 1, 1, 1, 0, 0, 2'b00, rs, rt, 5'd0);
  endfunction
  function automatic instr_t i_sw(input logic [4:0] rs, input logic [4:0] rt);
    return mk(0, 1, 0, 0, 0, 1, 0, 2'b00, rs, rt, 5'd0);
  endfunction
  function automatic instr_t i_beq(input logic [4:0] rs, input logic [4:0] rt);
    return mk(0, 0, 0, 0, 0, 0, 1, 2'b01, rs, rt, 5'd0);
  endfunction
  function automatic instr_t i_addi(input logic [4:0] rs, input logic [4:0] rt);
    return mk(0, 1, 0, 1, 0, 0, 0, 2'b00, rs, rt, 5'd0);
  endfunction

  function automatic instr_t rand_instr();
    logic [4:0] rs, rt, rd;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0:       return NOP;
      1:       return i_r(rs, rt, rd);
      2:       return i_lw(rs, rt);
      3:       return i_sw(rs, rt);
      4:       return i_beq(rs, rt);
      default: return i_addi(rs, rt);
    endcase
  endfunction

  // Reference model: whole instructions move EX -> MEM -> WB; outputs follow the rules directly.
  function automatic logic [4:0] dest_of(input instr_t i);
    if (!i.reg_write) return 5'd0;
    return i.reg_dst ? i.rd : i.rt;
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (pipe_m[1].reg_write && dest_of(pipe_m[1]) == src) return 2'b10;
    if (pipe_m[2].reg_write && dest_of(pipe_m[2]) == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic model_stall(input vec_t v);
    return v.id.valid && !v.bt && pipe_m[0].mem_read && pipe_m[0].rt != 5'd0 &&
           (pipe_m[0].rt == v.id.rs || pipe_m[0].rt == v.id.rt);
  endfunction

  task automatic model_step(input vec_t v);
    logic s;
    s = model_stall(v);
    if (!v.rst_n) begin
      for (int i = 0; i < 3; i++) pipe_m[i] = NOP;
    end else begin
      pipe_m[2] = pipe_m[1];
      pipe_m[1] = v.bt ? NOP : pipe_m[0];
      pipe_m[0] = (v.bt || s || !v.id.valid) ? NOP : v.id;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL c%0d %s: got %0h expected %0h", cyc, name, act, exp);
    end
  endtask

  task automatic row(input logic rst_n, input instr_t id, input logic bt, input logic x,
                     input logic st, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [1:0] aop, input logic mw, input logic rw,
                     input logic [4:0] dest);
    vec_t v;
    v = '{rst_n: rst_n, id: id, bt: bt, x_dst: x, chk: 1'b1, e_stall: st, e_fa: fa,
          e_fb: fb, e_aop: aop, e_mw: mw, e_rw: rw, e_dest: dest};
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    reset_n          = v.rst_n;
    bus.id_valid     = v.id.valid;
    bus.id_RegDst    = v.x_dst ? 1'bx : v.id.reg_dst;
    bus.id_ALUSrc    = v.id.alu_src;
    bus.id_MemtoReg  = v.id.memto_reg;
    bus.id_RegWrite  = v.id.reg_write;
    bus.id_MemRead   = v.id.mem_read;
    bus.id_MemWrite  = v.id.mem_write;
    bus.id_Branch    = v.id.branch;
    bus.id_AluOP     = v.id.alu_op;
    bus.id_rs        = v.id.rs;
    bus.id_rt        = v.id.rt;
    bus.id_rd        = v.id.rd;
    bus.branch_taken = v.bt;
  endtask

  task automatic checkOutput(input vec_t v);
    cmp("ex_ALUSrc",    32'(bus.ex_ALUSrc),    32'(pipe_m[0].alu_src));
    cmp("ex_AluOP",     32'(bus.ex_AluOP),     32'(pipe_m[0].alu_op));
    cmp("ex_rs",        32'(bus.ex_rs),        32'(pipe_m[0].rs));
    cmp("ex_rt",        32'(bus.ex_rt),        32'(pipe_m[0].rt));
    cmp("mem_MemRead",  32'(bus.mem_MemRead),  32'(pipe_m[1].mem_read));
    cmp("mem_MemWrite", 32'(bus.mem_MemWrite), 32'(pipe_m[1].mem_write));
    cmp("mem_Branch",   32'(bus.mem_Branch),   32'(pipe_m[1].branch));
    cmp("wb_MemtoReg",  32'(bus.wb_MemtoReg),  32'(pipe_m[2].memto_reg));
    cmp("wb_RegWrite",  32'(bus.wb_RegWrite),  32'(pipe_m[2].reg_write));
    cmp("wb_dest",      32'(bus.wb_dest),      32'(dest_of(pipe_m[2])));
    cmp("stall",        32'(bus.stall),        32'(model_stall(v)));
    cmp("fwd_a",        32'(bus.fwd_a),        32'(fwd_of(pipe_m[0].rs)));
    cmp("fwd_b",        32'(bus.fwd_b),        32'(fwd_of(pipe_m[0].rt)));
    if (v.chk) begin
      cmp("tbl.stall",        32'(bus.stall),        32'(v.e_stall));
      cmp("tbl.fwd_a",        32'(bus.fwd_a),        32'(v.e_fa));
      cmp("tbl.fwd_b",        32'(bus.fwd_b),        32'(v.e_fb));
      cmp("tbl.ex_AluOP",     32'(bus.ex_AluOP),     32'(v.e_aop));
      cmp("tbl.mem_MemWrite", 32'(bus.mem_MemWrite), 32'(v.e_mw));
      cmp("tbl.wb_RegWrite",  32'(bus.wb_RegWrite),  32'(v.e_rw));
      cmp("tbl.wb_dest",      32'(bus.wb_dest),      32'(v.e_dest));
    end
  endtask

  task automatic run_cycle(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v);
    @(posedge clk);
    last_stall = model_stall(v);
    model_step(v);
    #1;
    cyc++;
  endtask

  initial begin
    vec_t v;

    //   rst  id                  bt x  st fa     fb     aop    mw rw dest
    row(1, i_r(1, 2, 3),          0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 5'd3);
    row(1, i_lw(0, 4),            0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, i_r(4, 6, 8),          0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, i_r(4, 6, 8),          0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b01, 2'b00, 2'b10, 0, 1, 5'd4);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 5'd8);
    row(1, i_r(1, 2, 5),          0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, i_addi(1, 5),          0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0, 5'd0);
    row(1, i_r(5, 5, 9),          0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b10, 2'b10, 2'b10, 0, 1, 5'd5);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 5'd5);
    row(1, i_r(1, 2, 5),          0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 5'd9);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0, 5'd0);
    row(1, i_r(5, 5, 10),         0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b01, 2'b01, 2'b10, 0, 1, 5'd5);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 5'd10);
    row(1, i_r(1, 2, 11),         0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, i_beq(1, 2),           0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0, 5'd0);
    row(1, i_sw(3, 4),            0, 0, 0, 2'b00, 2'b00, 2'b01, 0, 0, 5'd0);
    row(1, i_r(3, 4, 7),          1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 5'd11);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, i_lw(0, 4),            0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, i_r(4, 4, 12),         1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, i_sw(2, 3),            0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, i_r(1, 2, 0),          0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, i_lw(1, 0),            0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0, 5'd0);
    row(1, i_r(0, 0, 13),         0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 1, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 5'd13);
    row(1, i_r(1, 2, 20),         0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, i_addi(1, 21),         0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0, 5'd0);
    row(0, i_r(20, 21, 22),       0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);
    row(1, NOP,                   0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5'd0);

    v = '{rst_n: 1'b0, id: NOP, bt: 1'b0, x_dst: 1'b0, chk: 1'b0, e_stall: 1'b0,
          e_fa: 2'b00, e_fb: 2'b00, e_aop: 2'b00, e_mw: 1'b0, e_rw: 1'b0, e_dest: 5'd0};
    applyStimulus(v);
    repeat (2) @(posedge clk);
    model_step(v);
    #1;

    $display("[TB] directed table: %0d rows", tbl.size());
    foreach (tbl[i]) run_cycle(tbl[i]);

    // Random traffic; IF/ID is held while the pipe reports a stall, as the front end would.
    v.chk = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!last_stall) v.id = rand_instr();
      v.bt    = pipe_m[1].branch && ($urandom_range(0, 1) == 1);
      v.rst_n = ($urandom_range(0, 59) != 0);
      v.x_dst = v.id.valid && !v.id.reg_write && ($urandom_range(0, 1) == 1);
      run_cycle(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
